sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Synthesizable single-clock FIFO: the responder end of fifo_if, driven by the fifo test driver/reader.
//  Accepts one write per cycle (wr/data) and one read per cycle (rd/q), reports full/mty plus
//  almost-full/empty, fill count and sticky overflow/underflow errors. Buffers data between producer and consumer.
// PARAMETERS
//  DATA_WIDTH     8   width of data and q
//  ADDR_WIDTH     4   storage address bits; DEPTH = 2**ADDR_WIDTH entries (16)
//  AFULL_THRESH   14  afull asserted when count >= AFULL_THRESH
//  AEMPTY_THRESH  2   aempty asserted when count <= AEMPTY_THRESH
// PORTS
//  clk      in   1             clock
//  rst_n    in   1             reset: one clock; reset is synchronous and active-low
//  wr       in   1             write request, sampled at posedge clk
//  data     in   DATA_WIDTH    write data, sampled with wr
//  rd       in   1             read request, sampled at posedge clk
//  q        out  DATA_WIDTH    read data, registered; holds until next accepted read
//  full     out  1             count == DEPTH
//  mty      out  1             count == 0
//  afull    out  1             count >= AFULL_THRESH
//  aempty   out  1             count <= AEMPTY_THRESH
//  count    out  ADDR_WIDTH+1  entries stored, 0..DEPTH
//  ovf      out  1             sticky: write dropped while full
//  udf      out  1             sticky: read ignored while empty
//  clr_err  in   1             synchronous clear of ovf/udf
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): wr_ptr=rd_ptr=0, count=0, q=0, mty=1, aempty=1, full=0,
//    afull=0, ovf=0, udf=0. Storage contents not reset. Reset mid-operation discards all data.
//  - Pointers ADDR_WIDTH+1 bits; MSB is wrap bit; address = low ADDR_WIDTH bits; wrap DEPTH-1 -> 0.
//  - wr_ok = wr & (!full | rd); rd_ok = rd & !mty. All flags/count registered, updated same edge.
//  - Write: at edge with wr_ok, mem[wr_ptr]<=data, wr_ptr++; visible to a read from the next cycle.
//  - Read latency 1: at edge with rd_ok, q<=mem[rd_ptr], rd_ptr++; q valid after that edge
//    (consumer samples at following negedge). No first-word fall-through.
//  - count: +1 on wr_ok&!rd_ok, -1 on rd_ok&!wr_ok, unchanged on both/neither.
//  - Full & wr & rd: both accepted, count stays DEPTH, full stays 1.
//  - Empty & wr & rd: write accepted, read ignored (udf set), q unchanged, count -> 1.
//  - Full & wr & !rd: write dropped, ovf<=1, no state change. Empty & rd: udf<=1, q unchanged.
//  - ovf/udf: set has priority over clr_err in same cycle; cleared by clr_err or reset only.
//  - Flags derive from next-count, so full/mty are exact in the cycle after the edge; no lag.
//  - Parameter rule: AEMPTY_THRESH < AFULL_THRESH <= DEPTH; elaboration $error otherwise.
// STRUCTURE
//  - fifo_pkg: default DATA_WIDTH/ADDR_WIDTH constants, ptr_t/count_t typedef helpers.
//  - Sub-module fifo_ram: simple dual-port array, 1 write port, 1 registered read port
//    (we/waddr/wdata, re/raddr/rdata). sync_fifo holds pointers, count, flags, error logic.
// TESTING (DEPTH=16, DATA_WIDTH=8)
//  - Reset -> mty=1 aempty=1 full=0 count=0 q=8'h00 ovf=udf=0.
//  - Write 8'hA5, 8'h3C; read twice -> q=A5 after 1st read edge, 3C after 2nd; mty=1, count=0.
//  - Write 16 random values -> full=1 afull=1 count=16; 17th write -> dropped, ovf=1;
//    drain 16 reads -> exact order matches, mty=1; clr_err -> ovf=0.
//  - Full + simultaneous wr(8'h77)&rd -> count stays 16, oldest value on q, 8'h77 read last.
//  - Empty + rd -> udf=1, q unchanged; empty + wr&rd -> count=1, udf=1, later read gives written value.
//  - 40 writes/reads interleaved across pointer wrap, then rst_n=0 with 5 entries stored -> count=0,
//    mty=1; next write/read returns new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and pointer/count type helpers
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
  typedef logic [ADDR_WIDTH_DEF:0] count_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage with one write port and a registered read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left unreset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read and write returns the old word, which the full wr+rd case relies on.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered flags, fill count and sticky errors
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full,
  output logic                  mty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf,
  input  logic                  clr_err
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo: require AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic full_q, mty_q, afull_q, aempty_q, ovf_q, ovf_d, udf_q, udf_d;
  logic wr_ok, rd_ok;

  // Reading while full frees a slot in the same edge, so the write still lands.
  assign wr_ok = wr & (~full_q | rd);
  assign rd_ok = rd & ~mty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(wr_ok);
    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(rd_ok);
    count_d  = count_q;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (wr && full_q && !rd) ovf_d = 1'b1;
    else if (clr_err)        ovf_d = 1'b0;
    udf_d = udf_q;
    if (rd && mty_q)         udf_d = 1'b1;
    else if (clr_err)        udf_d = 1'b0;
  end

  // Flags are computed from the next count so they never lag the data path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      mty_q    <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      mty_q    <= (count_d == '0);
      afull_q  <= (count_d >= AFULL_C);
      aempty_q <= (count_d <= AEMPTY_C);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (data),
    .re    (rd_ok),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (q)
  );

  assign full   = full_q;
  assign mty    = mty_q;
  assign afull  = afull_q;
  assign aempty = aempty_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo with directed vectors
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n, wr, rd, clr_err;
  logic [7:0] data, q;
  logic       full, mty, afull, aempty, ovf, udf;
  logic [4:0] count;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] q_exp;
  logic       ovf_exp, udf_exp;

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data(data), .rd(rd), .q(q),
    .full(full), .mty(mty), .afull(afull), .aempty(aempty), .count(count),
    .ovf(ovf), .udf(udf), .clr_err(clr_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read-data monitor: every accepted read queues its expected word here.
  always @(negedge clk) begin
    while (sb.size() > 0) chk("read_data", int'(q), int'(sb.pop_front()));
  end

  task automatic check_state();
    chk("count",  int'(count),  mq.size());
    chk("full",   int'(full),   int'(mq.size() == 16));
    chk("mty",    int'(mty),    int'(mq.size() == 0));
    chk("afull",  int'(afull),  int'(mq.size() >= 14));
    chk("aempty", int'(aempty), int'(mq.size() <= 2));
    chk("ovf",    int'(ovf),    int'(ovf_exp));
    chk("udf",    int'(udf),    int'(udf_exp));
    chk("q_hold", int'(q),      int'(q_exp));
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic clr);
    bit fl, em, wok, rok;
    wr = w; data = d; rd = r; clr_err = clr;
    fl  = (mq.size() == 16);
    em  = (mq.size() == 0);
    wok = w && (!fl || r);
    rok = r && !em;
    @(posedge clk);
    #1;
    if (w && fl && !r) ovf_exp = 1'b1; else if (clr) ovf_exp = 1'b0;
    if (r && em)       udf_exp = 1'b1; else if (clr) udf_exp = 1'b0;
    if (rok) begin
      q_exp = mq.pop_front();
      sb.push_back(q_exp);
    end
    if (wok) mq.push_back(d);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    q_exp = 8'h00; ovf_exp = 1'b0; udf_exp = 1'b0;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data = 8'h00;
    q_exp = 8'h00; ovf_exp = 1'b0; udf_exp = 1'b0;
    @(posedge clk);
    do_reset();
    chk("reset_q", int'(q), 8'h00);
    chk("reset_mty", int'(mty), 1);

    // Two writes, two reads
    cycle(1, 8'hA5, 0, 0);
    cycle(1, 8'h3C, 0, 0);
    cycle(0, 8'h00, 1, 0);
    chk("first_read", int'(q), 8'hA5);
    cycle(0, 8'h00, 1, 0);
    chk("second_read", int'(q), 8'h3C);
    chk("two_empty", int'(mty), 1);

    // Fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) cycle(1, 8'(i * 37 + 11), 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    cycle(1, 8'hEE, 0, 0);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_count", int'(count), 16);
    for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);
    chk("drain_last", int'(q), 8'(15 * 37 + 11));
    chk("drain_mty", int'(mty), 1);
    cycle(0, 8'h00, 0, 1);
    chk("ovf_clr", int'(ovf), 0);

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
    cycle(1, 8'h77, 1, 0);
    chk("full_wrrd_count", int'(count), 16);
    chk("full_wrrd_q", int'(q), 8'hC0);
    chk("full_wrrd_ovf", int'(ovf), 0);
    for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);
    chk("full_wrrd_last", int'(q), 8'h77);

    // Underflow cases
    cycle(0, 8'h00, 1, 0);
    chk("udf_set", int'(udf), 1);
    chk("udf_q_hold", int'(q), 8'h77);
    cycle(0, 8'h00, 1, 1);
    chk("udf_set_beats_clr", int'(udf), 1);
    cycle(0, 8'h00, 0, 1);
    chk("udf_clr", int'(udf), 0);
    cycle(1, 8'h5A, 1, 0);
    chk("empty_wrrd_count", int'(count), 1);
    chk("empty_wrrd_udf", int'(udf), 1);
    chk("empty_wrrd_q", int'(q), 8'h77);
    cycle(0, 8'h00, 1, 0);
    chk("empty_wrrd_read", int'(q), 8'h5A);
    cycle(0, 8'h00, 0, 1);

    // Interleaved traffic across pointer wrap, then mid-operation reset
    for (int i = 0; i < 40; i++) cycle(1, 8'(i * 3 + 1), (i % 4) != 0, 0);
    chk("wrap_count", int'(count), 10);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);
    chk("pre_reset_count", int'(count), 5);
    do_reset();
    chk("midreset_count", int'(count), 0);
    chk("midreset_mty", int'(mty), 1);
    chk("midreset_q", int'(q), 8'h00);
    cycle(1, 8'hC3, 0, 0);
    cycle(0, 8'h00, 1, 0);
    chk("post_reset_read", int'(q), 8'hC3);
    chk("post_reset_mty", int'(mty), 1);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
